// File: rtl/rv32_decode_pkg.sv
// Shared types for the RV32I decode stage: opcode constants, immediate-format
// selector and the decoded bundle carried through the output buffer.
package rv32_decode_pkg;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7MulDiv = 7'b0000001;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_we;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> decoded bundle.
// Fields a format does not use are reported as zero; an illegal encoding
// collapses to an all-zero bundle with only the illegal flag set.
// Optional feature: define DECODE_RV32M_EN to accept the M-extension OP encodings.
module rv32_decode_comb
    import rv32_decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    imm_fmt_e fmt;
    logic     legal;
    logic     use_rs1, use_rs2, use_rd, keep_f3, keep_f7;
    logic     op_f7_ok;

    // OP-type funct7 legality; the M encodings are gated by the build option.
    always_comb begin
        op_f7_ok = 1'b0;
        if (f7 == F7Base) begin
            op_f7_ok = 1'b1;
        end else if (f7 == F7Alt) begin
            op_f7_ok = (f3 == 3'b000) || (f3 == 3'b101);
        end else if (f7 == F7MulDiv) begin
`ifdef DECODE_RV32M_EN
            op_f7_ok = 1'b1;
`else
            op_f7_ok = 1'b0;
`endif
        end
    end

    // Opcode classification: format, legality and which fields are meaningful.
    always_comb begin
        fmt     = ImmNone;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        keep_f3 = 1'b0;
        keep_f7 = 1'b0;
        case (opcode)
            OpcLui, OpcAuipc: begin
                legal  = 1'b1;
                fmt    = ImmU;
                use_rd = 1'b1;
            end
            OpcJal: begin
                legal  = 1'b1;
                fmt    = ImmJ;
                use_rd = 1'b1;
            end
            OpcJalr: begin
                legal   = (f3 == 3'b000);
                fmt     = ImmI;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                keep_f3 = 1'b1;
            end
            OpcBranch: begin
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
                fmt     = ImmB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                keep_f3 = 1'b1;
            end
            OpcLoad: begin
                legal   = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                fmt     = ImmI;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                keep_f3 = 1'b1;
            end
            OpcStore: begin
                legal   = (f3 <= 3'b010);
                fmt     = ImmS;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                keep_f3 = 1'b1;
            end
            OpcOpImm: begin
                case (f3)
                    3'b001:  legal = (f7 == F7Base);
                    3'b101:  legal = (f7 == F7Base) || (f7 == F7Alt);
                    default: legal = 1'b1;
                endcase
                fmt     = ImmI;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                keep_f3 = 1'b1;
            end
            OpcOp: begin
                legal   = op_f7_ok;
                fmt     = ImmNone;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                keep_f3 = 1'b1;
                keep_f7 = 1'b1;
            end
            // FENCE and ECALL/EBREAK touch no architectural registers here.
            OpcMiscMem, OpcSystem: begin
                legal   = (f3 == 3'b000);
                fmt     = ImmI;
                keep_f3 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the bundle; illegal encodings become a canonical NOP.
    always_comb begin
        dec_o = '0;
        if (legal) begin
            dec_o.opcode   = opcode;
            dec_o.rs1      = use_rs1 ? instr_i[19:15] : 5'd0;
            dec_o.rs2      = use_rs2 ? instr_i[24:20] : 5'd0;
            dec_o.rd       = use_rd  ? instr_i[11:7]  : 5'd0;
            dec_o.funct3   = keep_f3 ? f3 : 3'd0;
            dec_o.funct7   = keep_f7 ? f7 : 7'd0;
            dec_o.rs1_used = use_rs1;
            dec_o.rs2_used = use_rs2;
            dec_o.rd_we    = use_rd && (instr_i[11:7] != 5'd0);
            case (fmt)
                ImmI:    dec_o.imm = imm_i;
                ImmS:    dec_o.imm = imm_s;
                ImmB:    dec_o.imm = imm_b;
                ImmU:    dec_o.imm = imm_u;
                ImmJ:    dec_o.imm = imm_j;
                default: dec_o.imm = 32'd0;
            endcase
        end else begin
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage: decodes on the way in and buffers results in a
// DEPTH-entry FIFO toward execute, with flush and a saturating count of illegal
// entries handed downstream.
// Optional feature: DECODE_RV32M_EN (see rv32_decode_comb).
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_rs1_used,
    output logic             out_rs2_used,
    output logic             out_rd_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_t        dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            push, pop;

    rv32_decode_comb u_decode (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign in_ready  = (occ_q != OccW'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Buffer write: the decoded bundle lands in the tail slot on push.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: in_pc, dec: dec};
        end
    end

    // Pointer/occupancy update; flush empties the buffer but a same-cycle pop
    // still counts toward the illegal counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                occ_d = occ_q + OccW'(1);
            end else if (!push && pop) begin
                occ_d = occ_q - OccW'(1);
            end
        end
        if (pop && head.dec.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; storage is cleared so the
    // output fields read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

    assign out_pc       = head.pc;
    assign out_opcode   = head.dec.opcode;
    assign out_rs1      = head.dec.rs1;
    assign out_rs2      = head.dec.rs2;
    assign out_rd       = head.dec.rd;
    assign out_funct3   = head.dec.funct3;
    assign out_funct7   = head.dec.funct7;
    assign out_imm      = head.dec.imm;
    assign out_rs1_used = head.dec.rs1_used;
    assign out_rs2_used = head.dec.rs2_used;
    assign out_rd_we    = head.dec.rd_we;
    assign out_illegal  = head.dec.illegal;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed self-checking bench for rv32_decode_stage.
// Small CNT_W so counter saturation is reachable.
module tb_rv32_decode_stage;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned CntMax = 7;

`ifdef DECODE_RV32M_EN
    localparam bit MulLegal = 1'b1;
`else
    localparam bit MulLegal = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic [PC_W-1:0]  out_pc;
    logic [6:0]       out_opcode, out_funct7;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic [2:0]       out_funct3;
    logic [31:0]      out_imm;
    logic             out_rs1_used, out_rs2_used, out_rd_we, out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    rv32_decode_stage #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_imm      (out_imm),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (illegal_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", illegal_cnt); end
        checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL reset_imm got %h want 0", out_imm); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h0000_1000;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d want 5", out_rd); end
        checks++; if (out_rs1 !== 5'd1) begin errors++; $display("FAIL addi_rs1 got %0d want 1", out_rs1); end
        checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        checks++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL addi_rd_we got %b want 1", out_rd_we); end
        checks++; if (out_rs2_used !== 1'b0) begin errors++; $display("FAIL addi_rs2_used got %b want 0", out_rs2_used); end
        checks++; if (out_pc !== 32'h0000_1000) begin errors++; $display("FAIL addi_pc got %h want 00001000", out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_popped got %b want 0", out_valid); end
    endtask

    task automatic test_store();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h0021A423; in_pc = 32'h0000_1004;
        tick();
        in_valid = 1'b0;
        checks++; if (out_rs1 !== 5'd3) begin errors++; $display("FAIL sw_rs1 got %0d want 3", out_rs1); end
        checks++; if (out_rs2 !== 5'd2) begin errors++; $display("FAIL sw_rs2 got %0d want 2", out_rs2); end
        checks++; if (out_imm !== 32'd8) begin errors++; $display("FAIL sw_imm got %h want 00000008", out_imm); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL sw_rd got %0d want 0", out_rd); end
        checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL sw_rd_we got %b want 0", out_rd_we); end
        checks++; if (out_rs2_used !== 1'b1) begin errors++; $display("FAIL sw_rs2_used got %b want 1", out_rs2_used); end
        checks++; if (out_funct3 !== 3'b010) begin errors++; $display("FAIL sw_funct3 got %b want 010", out_funct3); end
        tick();
    endtask

    task automatic test_branch_jal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h0000_1008;
        tick();
        checks++; if (out_imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_imm got %h want fffffffc", out_imm); end
        checks++; if (out_rs1_used !== 1'b1) begin errors++; $display("FAIL beq_rs1_used got %b want 1", out_rs1_used); end
        checks++; if (out_rd_we !== 1'b0) begin errors++; $display("FAIL beq_rd_we got %b want 0", out_rd_we); end
        in_instr = 32'h001000EF; in_pc = 32'h0000_100C;
        tick();
        in_valid = 1'b0;
        checks++; if (out_imm !== 32'h0000_0800) begin errors++; $display("FAIL jal_imm got %h want 00000800", out_imm); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL jal_rd got %0d want 1", out_rd); end
        checks++; if (out_rd_we !== 1'b1) begin errors++; $display("FAIL jal_rd_we got %b want 1", out_rd_we); end
        checks++; if (out_rs1_used !== 1'b0) begin errors++; $display("FAIL jal_rs1_used got %b want 0", out_rs1_used); end
        checks++; if (out_pc !== 32'h0000_100C) begin errors++; $display("FAIL jal_pc got %h want 0000100c", out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_popped got %b want 0", out_valid); end
    endtask

    // Simultaneous push and pop every cycle: occupancy stays at one.
    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF08293;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h0000_0600 + 32'(4 * i);
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0600 + 32'(4 * i)) begin
                errors++; $display("FAIL b2b_head[%0d] got v=%b pc=%h want v=1 pc=%h", i, out_valid,
                                   out_pc, 32'h0000_0600 + 32'(4 * i));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF08293;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            in_pc = 32'h0000_0100 + 32'(4 * i);
            tick();
            if (i == int'(DEPTH) - 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
            end
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0100 + 32'(4 * i)) begin
                errors++; $display("FAIL full_order[%0d] got v=%b pc=%h want v=1 pc=%h", i, out_valid,
                                   out_pc, 32'h0000_0100 + 32'(4 * i));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_extra got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] vec [8];
        bit          ill [8];
        vec = '{32'h00000000, 32'h02208033, 32'h40000033, 32'h40001033,
                32'h00003003, 32'h40005013, 32'h40001013, 32'h00002063};
        ill = '{1'b1, !MulLegal, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b1; in_instr = vec[i]; in_pc = 32'h0000_0400 + 32'(4 * i);
            tick();
            in_valid = 1'b0;
            checks++; if (out_illegal !== ill[i]) begin errors++; $display("FAIL illegal_flag[%h] got %b want %b", vec[i], out_illegal, ill[i]); end
            if (ill[i]) begin
                checks++; if (out_rd_we !== 1'b0 || out_imm !== 32'd0 || out_rs1_used !== 1'b0) begin
                    errors++; $display("FAIL illegal_nop[%h] got we=%b imm=%h rs1u=%b want 0", vec[i],
                                       out_rd_we, out_imm, out_rs1_used);
                end
            end else begin
                checks++; if (out_rs2_used !== (vec[i][6:0] == 7'b0110011)) begin
                    errors++; $display("FAIL legal_rs2u[%h] got %b", vec[i], out_rs2_used);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (ill[i] && exp_cnt < int'(CntMax)) exp_cnt++;
            checks++; if (illegal_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL illegal_cnt[%h] got %0d want %0d", vec[i], illegal_cnt, exp_cnt); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h0000_0200;
        tick();
        flush = 1'b1; in_pc = 32'h0000_0204;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush1_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush1_ready got %b want 1", in_ready); end
        checks++; if (illegal_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL flush1_cnt got %0d want %0d", illegal_cnt, exp_cnt); end
        in_valid = 1'b1; in_pc = 32'h0000_0210;
        tick();
        in_pc = 32'h0000_0214;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush2_full got %b want 0", in_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush2_empty got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_pc = 32'h0000_0220;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_0220) begin
            errors++; $display("FAIL flush_refill got v=%b pc=%h want v=1 pc=00000220", out_valid, out_pc);
        end
        // Replace with an illegal head, then flush while it is popped.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h0000_0230;
        tick();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        if (exp_cnt < int'(CntMax)) exp_cnt++;
        checks++; if (illegal_cnt !== CNT_W'(exp_cnt) || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_pop_cnt got cnt=%0d v=%b want cnt=%0d v=0", illegal_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        in_instr = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 32'h0000_0700 + 32'(4 * i);
            tick();
            in_valid = 1'b0; out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            if (exp_cnt < int'(CntMax)) exp_cnt++;
            checks++; if (illegal_cnt !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, illegal_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF08293; in_pc = 32'h0000_0500;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        exp_cnt = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        checks++; if (out_pc !== 32'd0 || illegal_cnt !== 3'd0) begin
            errors++; $display("FAIL mid_reset_data got pc=%h cnt=%0d want 0 0", out_pc, illegal_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_branch_jal();
        test_back_to_back();
        test_full();
        test_illegal();
        test_flush();
        test_saturate();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
